// File: rtl/write_sram.sv
// write_sram: ingress packet writer for the SRAM cache.
// Takes a sop/eop/vld word stream and packs it into 16-word SRAM blocks
// obtained from the free-block allocator. Every block opened is reported
// on o_blk_addr, and the offset of the eop word is reported on o_last_blk_n.
// Optional feature macro: WRITE_SRAM_PKT_LEN_EN adds o_pkt_len, the saturating
// accepted-word count of the packet, presented together with o_write_finish.
module write_sram #(
    parameter int AWIDTH     = 14,
    parameter int BLK_AWIDTH = 10,
    parameter int DWIDTH     = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_wr_sop,
    input  logic                         i_wr_eop,
    input  logic                         i_wr_vld,
    input  logic [DWIDTH-1:0]            i_wr_data,
    output logic                         o_wr_ready,
    output logic                         o_blk_req,
    input  logic [AWIDTH-1:0]            i_blk_addr,
    input  logic                         i_blk_addr_vld,
    output logic                         o_sram_wr_en,
    output logic [AWIDTH-1:0]            o_sram_wr_addr,
    output logic [DWIDTH-1:0]            o_sram_wr_data,
    output logic [AWIDTH-1:0]            o_blk_addr,
    output logic                         o_blk_addr_vld,
    output logic                         o_last_blk_vld,
    output logic [AWIDTH-BLK_AWIDTH-1:0] o_last_blk_n,
`ifdef WRITE_SRAM_PKT_LEN_EN
    output logic [15:0]                  o_pkt_len,
`endif
    output logic                         o_write_finish
);

    localparam int OFFW = AWIDTH - BLK_AWIDTH;
    localparam logic [OFFW-1:0] OFF_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READY,
        S_WRITE,
        S_NEXT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_base;
    logic [OFFW-1:0]     r_offset;

    logic                w_accept;
    logic                w_take;
    logic                w_alloc;

    logic                r_blk_req;
    logic                r_sram_wr_en;
    logic [AWIDTH-1:0]   r_sram_wr_addr;
    logic [DWIDTH-1:0]   r_sram_wr_data;
    logic [AWIDTH-1:0]   r_blk_addr;
    logic                r_blk_addr_vld;
    logic                r_last_blk_vld;
    logic [OFFW-1:0]     r_last_blk_n;
    logic                r_write_finish;

    // Ready comes straight from the registered state so it never depends on inputs.
    assign o_wr_ready = (r_state == S_READY) || (r_state == S_WRITE);

    // A word is accepted on handshake; it is written only inside a packet or when it opens one.
    assign w_accept = i_wr_vld && o_wr_ready;
    assign w_take   = w_accept && ((r_state == S_WRITE) || i_wr_sop);
    // Allocator responses only count while a block is actually being waited for.
    assign w_alloc  = i_blk_addr_vld && ((r_state == S_FETCH) || (r_state == S_NEXT));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; eop always goes back to IDLE so each packet starts in a fresh block.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (w_alloc) w_state_nxt = S_READY;
            S_READY: begin
                if (w_take) w_state_nxt = i_wr_eop ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                if (w_take) begin
                    if (i_wr_eop)                  w_state_nxt = S_IDLE;
                    else if (r_offset == OFF_LAST) w_state_nxt = S_NEXT;
                end
            end
            S_NEXT:  if (w_alloc) w_state_nxt = S_WRITE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Block base and word offset: reloaded on allocation, advanced per written word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base   <= '0;
            r_offset <= '0;
        end else if (w_alloc) begin
            r_base   <= i_blk_addr;
            r_offset <= '0;
        end else if (w_take) begin
            r_offset <= r_offset + 1'b1;
        end
    end

    // Block request pulses once from IDLE and once on each entry into NEXT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blk_req <= 1'b0;
        end else begin
            r_blk_req <= (r_state == S_IDLE) ||
                         ((w_state_nxt == S_NEXT) && (r_state != S_NEXT));
        end
    end

    // Registered SRAM write and reporting pulses, one cycle after the accepted word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sram_wr_en   <= 1'b0;
            r_sram_wr_addr <= '0;
            r_sram_wr_data <= '0;
            r_blk_addr     <= '0;
            r_blk_addr_vld <= 1'b0;
            r_last_blk_vld <= 1'b0;
            r_last_blk_n   <= '0;
            r_write_finish <= 1'b0;
        end else begin
            r_sram_wr_en   <= w_take;
            r_sram_wr_addr <= w_take ? (r_base + {{BLK_AWIDTH{1'b0}}, r_offset}) : '0;
            r_sram_wr_data <= w_take ? i_wr_data : '0;
            r_blk_addr_vld <= w_take && (r_offset == '0);
            r_blk_addr     <= (w_take && (r_offset == '0)) ? r_base : '0;
            r_last_blk_vld <= w_take && i_wr_eop;
            r_last_blk_n   <= (w_take && i_wr_eop) ? r_offset : '0;
            r_write_finish <= w_take && i_wr_eop;
        end
    end

    assign o_blk_req      = r_blk_req;
    assign o_sram_wr_en   = r_sram_wr_en;
    assign o_sram_wr_addr = r_sram_wr_addr;
    assign o_sram_wr_data = r_sram_wr_data;
    assign o_blk_addr     = r_blk_addr;
    assign o_blk_addr_vld = r_blk_addr_vld;
    assign o_last_blk_vld = r_last_blk_vld;
    assign o_last_blk_n   = r_last_blk_n;
    assign o_write_finish = r_write_finish;

`ifdef WRITE_SRAM_PKT_LEN_EN
    logic [15:0] r_len;
    logic [15:0] w_len_nxt;
    logic [15:0] r_pkt_len;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The sop word restarts the count at 1; later words add one, holding at all-ones.
    assign w_len_nxt = (r_state == S_READY) ? 16'd1 : sat_inc(r_len);

    // Running packet length and its value presented alongside the finish pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len     <= '0;
            r_pkt_len <= '0;
        end else begin
            if (w_take) r_len <= w_len_nxt;
            r_pkt_len <= (w_take && i_wr_eop) ? w_len_nxt : 16'd0;
        end
    end

    assign o_pkt_len = r_pkt_len;
`endif

endmodule
